// File: rtl/pwm_to_servo.sv
// pwm_to_servo
//   Servo-pulse decoder. Measures the high time of a servo-style PWM frame
//   and reports it in servo units of CLK_PER_UNIT clocks, truncated.
//   A pulse reaching 2048 units is discarded and flagged as overflow.
//   Loss of rising edges for TIMEOUT_CLKS clocks raises signal_lost.
//
// Parameters
//   CLK_PER_UNIT  clocks per servo unit (>= 2)
//   TIMEOUT_CLKS  clocks without a rising edge before signal_lost
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   pwm_in       asynchronous PWM input pin
//   servo_val    last good measurement (11 bits, servo units)
//   valid        one-cycle strobe, servo_val updated this cycle
//   overflow     one-cycle strobe, pulse exceeded 2047 units and was dropped
//   signal_lost  level, no rising edge for TIMEOUT_CLKS clocks
module pwm_to_servo #(
  parameter int unsigned CLK_PER_UNIT = 2000,
  parameter int unsigned TIMEOUT_CLKS = 4_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [10:0] servo_val,
  output logic        valid,
  output logic        overflow,
  output logic        signal_lost
);

  localparam int unsigned PW = (CLK_PER_UNIT > 2) ? $clog2(CLK_PER_UNIT) : 1;
  localparam int unsigned FW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_UNIT - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {
    ST_ARM,
    ST_IDLE,
    ST_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [1:0]    fill_q, fill_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [10:0]   units_q, units_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [10:0]   servo_val_q, servo_val_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic          signal_lost_q, signal_lost_d;

  always_comb begin
    s1_d          = pwm_in;
    s2_d          = s1_q;
    // Marks the synchronizer as holding real samples; until then s2 still
    // shows its reset value and ARM must not mistake it for a low input.
    fill_d        = {fill_q[0], 1'b1};
    state_d       = state_q;
    pre_d         = pre_q;
    units_d       = units_q;
    servo_val_d   = servo_val_q;
    valid_d       = 1'b0;
    overflow_d    = 1'b0;
    signal_lost_d = signal_lost_q;
    frame_d       = (frame_q == FRAME_MAX) ? frame_q : frame_q + FW'(1);

    case (state_q)
      ST_ARM: begin
        if (fill_q[1] && !s2_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (s2_q) begin
          // The first high sample is already counted here.
          pre_d   = PW'(1);
          units_d = '0;
          frame_d = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (!s2_q) begin
          servo_val_d   = units_q;
          valid_d       = 1'b1;
          signal_lost_d = 1'b0;
          state_d       = ST_IDLE;
        end else if (pre_q == PRE_LAST) begin
          if (units_q == '1) begin
            overflow_d = 1'b1;
            state_d    = ST_ARM;
          end else begin
            pre_d   = '0;
            units_d = units_q + 11'd1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: state_d = ST_ARM;
    endcase

    // Only the step onto the saturation value raises the flag, so a valid
    // after a long silence is not immediately followed by a new loss.
    if ((frame_q != FRAME_MAX) && (frame_d == FRAME_MAX)) begin
      signal_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_ARM;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      fill_q        <= '0;
      pre_q         <= '0;
      units_q       <= '0;
      frame_q       <= '0;
      servo_val_q   <= '0;
      valid_q       <= 1'b0;
      overflow_q    <= 1'b0;
      signal_lost_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      fill_q        <= fill_d;
      pre_q         <= pre_d;
      units_q       <= units_d;
      frame_q       <= frame_d;
      servo_val_q   <= servo_val_d;
      valid_q       <= valid_d;
      overflow_q    <= overflow_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign servo_val   = servo_val_q;
  assign valid       = valid_q;
  assign overflow    = overflow_q;
  assign signal_lost = signal_lost_q;

endmodule

// File: doc/pwm_to_servo.md
# pwm_to_servo

Servo-pulse decoder: measures the high time of an incoming 20 ms servo-style PWM frame and returns it as an 11-bit servo value in the same units `servo_to_PWM` consumes (1 unit = 2000 clocks = 20 µs at 100 MHz). It is the receive-side counterpart of that generator. It sits between an external PWM pin (e.g. an RC receiver channel) and the steering/drive logic, and is also used in loopback to check generator outputs.

## Interface
- `CLK_PER_UNIT`, default 2000: clocks per servo unit.
- `TIMEOUT_CLKS`, default 4_000_000: clocks without a rising edge before declaring signal loss (two 20 ms frames).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `pwm_in` in 1: asynchronous PWM input pin.
- `servo_val` out 11: last good measurement, units of `CLK_PER_UNIT`.
- `valid` out 1: one-cycle strobe; `servo_val` updated this cycle.
- `overflow` out 1: one-cycle strobe; pulse exceeded 2047 units, discarded.
- `signal_lost` out 1: level; no rising edge for `TIMEOUT_CLKS` clocks.

## Operation
- Input path: 2-flop synchronizer `s1`→`s2`, both reset to 0; the FSM uses only `s2`.
- Counters: `pre` (prescaler, 0..`CLK_PER_UNIT`-1), `units` (11-bit), `frame` (since last rise, saturating at `TIMEOUT_CLKS`).
- States:
  - ARM (reset state): wait for `s2`=0, then go to IDLE. Guarantees no partial first pulse is measured.
  - IDLE: on `s2`=1, set `pre`=1, `units`=0, `frame`=0, go to HIGH.
  - HIGH: each cycle with `s2`=1, increment `pre`. When `pre`=`CLK_PER_UNIT`-1, set `pre`=0 and increment `units`.
    - On `s2`=0: `servo_val`=`units`, `valid`=1, `signal_lost`=0, go to IDLE.
    - If `units`=2047 and the next increment would wrap: pulse `overflow`, leave `servo_val` unchanged, go to ARM.
- Arithmetic: result = floor(N / `CLK_PER_UNIT`), where N is the number of clocks `s2` was high (truncation, no rounding).
  - A generator pulse of k·2000+1 clocks decodes to exactly k.
  - A 0-unit pulse (shorter than `CLK_PER_UNIT` clocks) gives `valid` with `servo_val`=0.
- Timeout: `frame` increments every cycle in every state except on the IDLE→HIGH transition, where it is cleared.
  - When `frame` reaches `TIMEOUT_CLKS`, set `signal_lost`=1.
  - `signal_lost` is sticky until the next `valid`.
  - `servo_val` is held, not cleared.
- Stuck-high input: the pulse saturates and reports `overflow` (2047 units ≈ 41 ms). The block then sits in ARM; timeout asserts `signal_lost`.
- `valid` and `overflow` are never high in the same cycle.

## Timing
- Reset values: `servo_val`=0, `valid`=0, `overflow`=0, `signal_lost`=1, state=ARM, all counters 0.
- Asynchronous reset mid-pulse aborts the measurement. After release the block returns to ARM, and that pulse is never reported.
- Latency:
  - `valid` is high in the cycle after the third rising `clk` edge, counting the edge that first samples `pwm_in` low.
  - `servo_val` changes in the same cycle as `valid`.
- Rise-to-count alignment: N equals the number of `clk` edges that sample `pwm_in` high. Both edges pass through the same 2-cycle synchronizer delay.
- Minimum low time between pulses: 1 synchronized cycle. Back-to-back frames with 1 low cycle are each reported.
- `signal_lost` rises exactly `TIMEOUT_CLKS` cycles after the cycle of the last IDLE→HIGH transition, or after reset release.

## Test plan
- Reset release with `pwm_in`=0, then a pulse high for 150_001 clocks → one `valid` with `servo_val`=75. `signal_lost` drops with `valid`.
- Loopback from `servo_to_PWM` with `servo_L`=100, then 50, over 3 frames each → `valid` every 2_000_001 clocks, `servo_val`=100 then 50. No `overflow`.
- `pwm_in` already high at reset release, falling after 10_000 clocks → no `valid` for that pulse. The next 2001-clock pulse gives `servo_val`=1.
- Boundaries: pulses of 1999, 2000, 4_094_000 and 4_096_000 clocks → values 0, 1, 2047, then `overflow` with `servo_val` still 2047.
- `pwm_in` held low for 4_000_000 clocks after a valid frame → `signal_lost`=1 and `servo_val` held. The next pulse restores `signal_lost`=0 on its `valid`.
- `rst` pulsed low for 1 cycle mid-pulse → all outputs at reset values immediately. That pulse is not reported, and the next full pulse decodes correctly.
